clk_enable_gen: RTL

//  Multi-channel programmable clock-enable generator. Replaces the fixed free-running

---
 rtl/clk_en_pkg.sv | 24 ++
 rtl/clk_en_chan.sv | 74 +++++++
 rtl/clk_enable_gen.sv | 80 ++++++++
 3 files changed

// File: rtl/clk_en_pkg.sv
// Shared types and defaults for the clock-enable generator.
// Mode encoding, cfg mode decode, reset constants.
package clk_en_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10
  } mode_e;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_DIV_W   = 26;
  localparam int DEF_RST_DIV = 31;

  // Encoding 11 is reserved and parks the channel.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_RUN;
      2'b10:   return MODE_STEP;
      default: return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: counter, divisor, mode and step state.
// Emits a registered one-cycle tick every div+1 counting cycles.
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int RST_DIV = DEF_RST_DIV,
  parameter bit RST_RUN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_apply,
  input  logic [DIV_W-1:0] i_div,
  input  mode_e            i_mode,
  input  logic             i_step_req,
  output logic             o_at_boundary,
  output logic             o_tick,
  output logic             o_phase,
  output logic             o_running
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  mode_e            r_mode;
  logic             r_step_pend;
  logic             r_tick;
  logic             r_phase;

  logic w_active;
  logic w_term;

  // Counting in RUN, or in STEP while a single step is in flight.
  assign w_active = (r_mode == MODE_RUN) ||
                    ((r_mode == MODE_STEP) && r_step_pend);
  assign w_term   = w_active && (r_cnt == r_div);

  // Idle channels take new settings at once, counting ones only at terminal count.
  assign o_at_boundary = !w_active || w_term;
  assign o_tick        = r_tick;
  assign o_phase       = r_phase;
  assign o_running     = w_active;

  // Counter, tick/phase generation and config load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_div       <= DIV_W'(RST_DIV);
      r_mode      <= RST_RUN ? MODE_RUN : MODE_OFF;
      r_step_pend <= 1'b0;
      r_tick      <= 1'b0;
      r_phase     <= 1'b0;
    end else begin
      r_tick <= w_term;
      if (w_term) r_phase <= ~r_phase;
      if (i_apply) begin
        r_cnt       <= '0;
        r_div       <= i_div;
        r_mode      <= i_mode;
        r_step_pend <= 1'b0;
      end else if (w_active) begin
        if (w_term) begin
          r_cnt       <= '0;
          r_step_pend <= 1'b0;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end else begin
        r_cnt <= '0;
        if ((r_mode == MODE_STEP) && i_step_req) r_step_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator.
// Single pending config slot, applied per channel at a period boundary.
module clk_enable_gen
  import clk_en_pkg::*;
#(
  parameter int              N_CH         = DEF_N_CH,
  parameter int              DIV_W        = DEF_DIV_W,
  parameter int              RST_DIV      = DEF_RST_DIV,
  parameter logic [N_CH-1:0] RST_RUN_MASK = N_CH'(1),
  localparam int             CH_W         = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_chan,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  input  logic [N_CH-1:0]  step_req,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  phase,
  output logic [N_CH-1:0]  running
);

  logic             r_pend_valid;
  logic [CH_W-1:0]  r_pend_chan;
  logic [DIV_W-1:0] r_pend_div;
  mode_e            r_pend_mode;

  logic [N_CH-1:0] w_bound;
  logic [N_CH-1:0] w_apply;
  logic            w_chan_bad;
  logic            w_accept;

  assign cfg_ready  = !r_pend_valid;
  assign w_accept   = cfg_valid && cfg_ready;
  assign w_chan_bad = r_pend_valid &&
                      ({1'b0, r_pend_chan} >= (CH_W+1)'(N_CH));

  // Pending slot: filled on handshake, emptied by apply or bad channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_chan  <= '0;
      r_pend_div   <= '0;
      r_pend_mode  <= MODE_OFF;
    end else if (w_accept) begin
      r_pend_valid <= 1'b1;
      r_pend_chan  <= cfg_chan;
      r_pend_div   <= cfg_div;
      r_pend_mode  <= decode_mode(cfg_mode);
    end else if ((|w_apply) || w_chan_bad) begin
      r_pend_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_apply[g] = r_pend_valid &&
                        (r_pend_chan == CH_W'(g)) &&
                        w_bound[g];

    clk_en_chan #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV),
      .RST_RUN (RST_RUN_MASK[g])
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .i_apply       (w_apply[g]),
      .i_div         (r_pend_div),
      .i_mode        (r_pend_mode),
      .i_step_req    (step_req[g]),
      .o_at_boundary (w_bound[g]),
      .o_tick        (tick[g]),
      .o_phase       (phase[g]),
      .o_running     (running[g])
    );
  end

endmodule
